// File: rtl/mod_settings_loader.sv
// mod_settings_loader
// Polls the control flag word (address 0x00) of the controller BRAM every
// cycle while idle. A rising edge on flag bit 0 starts a burst read of the
// eleven settings words (0x21..0x2B) into shadow registers. When the last
// word returns, all settings are committed to the outputs together and
// UPDATE pulses for one cycle.
//
// Optional build macro MOD_SETTINGS_VALIDATE_EN: a commit whose requested
// segment has a zero frequency divider is rejected. The outputs are kept,
// UPDATE stays low and ERR pulses for one cycle. Without the macro every load
// commits and ERR is tied low.
//
// Ports
//   CLK, RST_N         clock, synchronous active-low reset
//   BRAM_EN, BRAM_ADDR read request to the controller BRAM (registered)
//   BRAM_DOUT          read data, RD_LATENCY cycles after the request cycle
//   REQ_RD_SEGMENT, CYCLE_0/1, FREQ_DIV_0/1, REP_0/1   committed settings
//   UPDATE             one-cycle commit strobe
//   BUSY               high whenever not idle
//   ERR                one-cycle reject strobe
//
// state  | meaning
// IDLE   | poll flag word every cycle, look for 0->1 on bit 0
// LOAD   | issue reads 0x21..0x2B, one per cycle
// DRAIN  | no reads, wait for word 0x2B to return
// COMMIT | UPDATE (or ERR) visible for this cycle, then back to IDLE

module mod_settings_loader #(
    parameter int RD_LATENCY = 2
) (
    input  logic        CLK,
    input  logic        RST_N,
    output logic        BRAM_EN,
    output logic [7:0]  BRAM_ADDR,
    input  logic [15:0] BRAM_DOUT,
    output logic        REQ_RD_SEGMENT,
    output logic [15:0] CYCLE_0,
    output logic [15:0] CYCLE_1,
    output logic [31:0] FREQ_DIV_0,
    output logic [31:0] FREQ_DIV_1,
    output logic [31:0] REP_0,
    output logic [31:0] REP_1,
    output logic        UPDATE,
    output logic        BUSY,
    output logic        ERR
);

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN, COMMIT} state_t;

    state_t      state_q, state_d;
    logic        en_q, en_d;
    logic [7:0]  addr_q, addr_d;
    logic        prev_q, prev_d;

    // Each request carries its address through the latency pipeline, so a
    // returning word is identified by its tag rather than by FSM timing.
    logic        vld_q [RD_LATENCY];
    logic [7:0]  tag_q [RD_LATENCY];
    logic        ret_vld;
    logic [7:0]  ret_tag;
    logic        poll_ret;
    logic        last_ret;
    logic        commit_go;
    logic        commit_ok;

    logic        sh_seg_q;
    logic [15:0] sh_cyc0_q, sh_cyc1_q;
    logic [31:0] sh_fd0_q, sh_fd1_q, sh_rep0_q;
    logic [15:0] sh_rep1_lo_q;

    logic        seg_q;
    logic [15:0] cyc0_q, cyc1_q;
    logic [31:0] fd0_q, fd1_q, rep0_q, rep1_q;
    logic        update_q;

    assign ret_vld   = vld_q[RD_LATENCY-1];
    assign ret_tag   = tag_q[RD_LATENCY-1];
    // Polls still in flight when IDLE is left are dropped here.
    assign poll_ret  = ret_vld && (ret_tag == 8'h00) && (state_q == IDLE);
    assign last_ret  = ret_vld && (ret_tag == 8'h2B);
    assign commit_go = (state_q == DRAIN) && last_ret;

`ifdef MOD_SETTINGS_VALIDATE_EN
    // All freq_div words arrive before 0x2B, so the shadows are final here.
    assign commit_ok = sh_seg_q ? (sh_fd1_q != 32'd0) : (sh_fd0_q != 32'd0);
`else
    assign commit_ok = 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        en_d    = 1'b0;
        addr_d  = 8'h00;
        prev_d  = prev_q;
        case (state_q)
            IDLE: begin
                en_d = 1'b1;
                if (poll_ret) begin
                    prev_d = BRAM_DOUT[0];
                    if (BRAM_DOUT[0] && !prev_q) begin
                        state_d = LOAD;
                        addr_d  = 8'h21;
                    end
                end
            end
            LOAD: begin
                if (addr_q == 8'h2B) begin
                    state_d = DRAIN;
                end else begin
                    en_d   = 1'b1;
                    addr_d = addr_q + 8'd1;
                end
            end
            DRAIN: begin
                if (last_ret) state_d = COMMIT;
            end
            COMMIT: begin
                state_d = IDLE;
                en_d    = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= IDLE;
            en_q    <= 1'b0;
            addr_q  <= 8'h00;
            prev_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            en_q    <= en_d;
            addr_q  <= addr_d;
            prev_q  <= prev_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            for (int i = 0; i < RD_LATENCY; i++) begin
                vld_q[i] <= 1'b0;
                tag_q[i] <= 8'h00;
            end
        end else begin
            vld_q[0] <= en_q;
            tag_q[0] <= addr_q;
            for (int i = 1; i < RD_LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1];
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            sh_seg_q     <= 1'b0;
            sh_cyc0_q    <= 16'h0;
            sh_cyc1_q    <= 16'h0;
            sh_fd0_q     <= 32'h0;
            sh_fd1_q     <= 32'h0;
            sh_rep0_q    <= 32'h0;
            sh_rep1_lo_q <= 16'h0;
        end else if (ret_vld) begin
            case (ret_tag)
                8'h21: sh_seg_q             <= BRAM_DOUT[0];
                8'h22: sh_cyc0_q            <= BRAM_DOUT;
                8'h23: sh_fd0_q[15:0]       <= BRAM_DOUT;
                8'h24: sh_fd0_q[31:16]      <= BRAM_DOUT;
                8'h25: sh_cyc1_q            <= BRAM_DOUT;
                8'h26: sh_fd1_q[15:0]       <= BRAM_DOUT;
                8'h27: sh_fd1_q[31:16]      <= BRAM_DOUT;
                8'h28: sh_rep0_q[15:0]      <= BRAM_DOUT;
                8'h29: sh_rep0_q[31:16]     <= BRAM_DOUT;
                8'h2A: sh_rep1_lo_q         <= BRAM_DOUT;
                default: ;
            endcase
        end
    end

    // Outputs load on the edge that enters COMMIT so they are valid in the
    // same cycle as UPDATE; the final word (rep1 high) bypasses its shadow.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            seg_q    <= 1'b0;
            cyc0_q   <= 16'h0;
            cyc1_q   <= 16'h0;
            fd0_q    <= 32'h0;
            fd1_q    <= 32'h0;
            rep0_q   <= 32'h0;
            rep1_q   <= 32'h0;
            update_q <= 1'b0;
        end else begin
            update_q <= 1'b0;
            if (commit_go && commit_ok) begin
                seg_q    <= sh_seg_q;
                cyc0_q   <= sh_cyc0_q;
                cyc1_q   <= sh_cyc1_q;
                fd0_q    <= sh_fd0_q;
                fd1_q    <= sh_fd1_q;
                rep0_q   <= sh_rep0_q;
                rep1_q   <= {BRAM_DOUT, sh_rep1_lo_q};
                update_q <= 1'b1;
            end
        end
    end

`ifdef MOD_SETTINGS_VALIDATE_EN
    logic err_q;
    always_ff @(posedge CLK) begin
        if (!RST_N) err_q <= 1'b0;
        else        err_q <= commit_go && !commit_ok;
    end
    assign ERR = err_q;
`else
    assign ERR = 1'b0;
`endif

    assign BRAM_EN        = en_q;
    assign BRAM_ADDR      = addr_q;
    assign REQ_RD_SEGMENT = seg_q;
    assign CYCLE_0        = cyc0_q;
    assign CYCLE_1        = cyc1_q;
    assign FREQ_DIV_0     = fd0_q;
    assign FREQ_DIV_1     = fd1_q;
    assign REP_0          = rep0_q;
    assign REP_1          = rep1_q;
    assign UPDATE         = update_q;
    assign BUSY           = (state_q != IDLE);

endmodule
